// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a rotating priority pointer and a per-grant hold quantum.
// A grant is revoked on owner release or, if others wait, on quantum expiry.
module round_robin_arbiter #(
   parameter int NUMBER_OF_DEVICES   = 4,
   parameter int DEVICE_NUMBER_WIDTH = $clog2(NUMBER_OF_DEVICES),
   parameter int MAX_HOLD_CYCLES     = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUMBER_OF_DEVICES-1:0]   requests,
   output logic [NUMBER_OF_DEVICES-1:0]   grants,
   output logic [DEVICE_NUMBER_WIDTH-1:0] grantedDevice,
   output logic                           grantValid,
   output logic                           preempted
);

   localparam int HOLD_WIDTH = $clog2(MAX_HOLD_CYCLES);
   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANTED,
      RELEASE
   } state_e;

   state_e                         state_q, state_d;
   logic [NUMBER_OF_DEVICES-1:0]   grants_q, grants_d;
   logic [DEVICE_NUMBER_WIDTH-1:0] granted_device_q, granted_device_d;
   logic                           grant_valid_q, grant_valid_d;
   logic                           preempted_q, preempted_d;
   logic [DEVICE_NUMBER_WIDTH-1:0] pointer_q, pointer_d;
   logic [HOLD_WIDTH-1:0]          hold_counter_q, hold_counter_d;

   logic                           scan_found;
   logic [DEVICE_NUMBER_WIDTH-1:0] scan_winner;
   logic                           owner_requesting;
   logic                           others_requesting;
   logic                           quantum_expired;

   // Scan from the highest offset down so the lowest offset from the pointer wins last.
   always_comb begin
      scan_found  = 1'b0;
      scan_winner = '0;
      for (int i = NUMBER_OF_DEVICES - 1; i >= 0; i--) begin
         if (requests[(int'(pointer_q) + i) % NUMBER_OF_DEVICES]) begin
            scan_found  = 1'b1;
            scan_winner = DEVICE_NUMBER_WIDTH'((int'(pointer_q) + i) % NUMBER_OF_DEVICES);
         end
      end
   end

   assign owner_requesting  = requests[granted_device_q];
   assign others_requesting = |(requests & ~grants_q);
   assign quantum_expired   = (hold_counter_q == HOLD_LAST);

   always_comb begin
      // NOTE: every _d takes its held value first so no path can infer a latch.
      state_d          = state_q;
      grants_d         = grants_q;
      granted_device_d = granted_device_q;
      grant_valid_d    = grant_valid_q;
      preempted_d      = 1'b0;
      pointer_d        = pointer_q;
      hold_counter_d   = hold_counter_q;

      unique case (state_q)
         IDLE: begin
            if (scan_found) begin
               grants_d              = '0;
               grants_d[scan_winner] = 1'b1;
               granted_device_d      = scan_winner;
               grant_valid_d         = 1'b1;
               pointer_d             = DEVICE_NUMBER_WIDTH'((int'(scan_winner) + 1) % NUMBER_OF_DEVICES);
               hold_counter_d        = '0;
               state_d               = GRANTED;
            end
         end
         GRANTED: begin
            hold_counter_d = quantum_expired ? hold_counter_q : hold_counter_q + 1'b1;
            // Owner release is checked first so a simultaneous drop never reports preemption.
            if (!owner_requesting) begin
               grants_d      = '0;
               grant_valid_d = 1'b0;
               state_d       = RELEASE;
            end else if (quantum_expired && others_requesting) begin
               grants_d      = '0;
               grant_valid_d = 1'b0;
               preempted_d   = 1'b1;
               state_d       = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            grants_d      = '0;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (reset) begin
         state_q          <= IDLE;
         grants_q         <= '0;
         granted_device_q <= '0;
         grant_valid_q    <= 1'b0;
         preempted_q      <= 1'b0;
         pointer_q        <= '0;
         hold_counter_q   <= '0;
      end else begin
         state_q          <= state_d;
         grants_q         <= grants_d;
         granted_device_q <= granted_device_d;
         grant_valid_q    <= grant_valid_d;
         preempted_q      <= preempted_d;
         pointer_q        <= pointer_d;
         hold_counter_q   <= hold_counter_d;
      end
   end

   assign grants        = grants_q;
   assign grantedDevice = granted_device_q;
   assign grantValid    = grant_valid_q;
   assign preempted     = preempted_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter: a cycle-level reference model pushes expected
// outputs per edge, an independent monitor pops and compares on the falling edge.
module tb_round_robin_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] requests;
   logic [N-1:0] grants;
   logic [1:0]   grantedDevice;
   logic         grantValid;
   logic         preempted;

   round_robin_arbiter #(
      .NUMBER_OF_DEVICES   (N),
      .DEVICE_NUMBER_WIDTH (2),
      .MAX_HOLD_CYCLES     (HOLD)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .requests      (requests),
      .grants        (grants),
      .grantedDevice (grantedDevice),
      .grantValid    (grantValid),
      .preempted     (preempted)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [N-1:0] grants;
      logic [1:0]   dev;
      logic         valid;
      logic         pre;
      string        tag;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   stim_done   = 0;
   string phase = "init";

   // Reference model: owner index (-1 = none), cycles the grant has been visible,
   // forced-idle cycles still owed after a revocation, and the next-priority device.
   int m_owner = -1;
   int m_last  = 0;
   int m_held  = 0;
   int m_cool  = 0;
   int m_ptr   = 0;
   bit m_pre   = 0;

   task automatic model_step(input logic [N-1:0] r, input logic rst);
      m_pre = 0;
      if (rst) begin
         m_owner = -1; m_last = 0; m_held = 0; m_cool = 0; m_ptr = 0;
      end else if (m_owner >= 0) begin
         m_held++;
         if (!r[m_owner]) begin
            m_owner = -1; m_cool = 1;
         end else if (m_held >= HOLD && (r & ~(N'(1) << m_owner)) != 0) begin
            m_owner = -1; m_cool = 1; m_pre = 1;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         for (int i = 0; i < N; i++) begin
            int d;
            d = (m_ptr + i) % N;
            if (r[d]) begin
               m_owner = d; m_last = d; m_held = 0; m_ptr = (d + 1) % N;
               break;
            end
         end
      end
   endtask

   task automatic apply(input logic [N-1:0] r, input logic rst);
      exp_t e;
      requests = r;
      reset    = rst;
      @(posedge clock);
      model_step(r, rst);
      e.grants = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e.dev    = 2'(m_last);
      e.valid  = (m_owner >= 0);
      e.pre    = m_pre;
      e.tag    = phase;
      sb_q.push_back(e);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected entry per edge, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".grants"},    8'(grants),         8'(e.grants));
            check({e.tag, ".device"},    8'(grantedDevice),  8'(e.dev));
            check({e.tag, ".valid"},     8'(grantValid),     8'(e.valid));
            check({e.tag, ".preempted"}, 8'(preempted),      8'(e.pre));
            check({e.tag, ".onehot0"},   8'($onehot0(grants)), 8'd1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, stimulus done=%0d", stim_done);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] r;
      requests = '0;
      reset    = 1'b1;

      phase = "reset";
      repeat (2) apply(4'b0000, 1'b1);

      // Device 1 wins from pointer 0, holds, then releases to device 2.
      phase = "grant_then_drop";
      repeat (4) apply(4'b0110, 1'b0);
      repeat (6) apply(4'b0100, 1'b0);
      repeat (3) apply(4'b0000, 1'b0);

      // All requesting: quantum rotation with preemption pulses.
      phase = "all_request";
      repeat (45) apply(4'b1111, 1'b0);
      repeat (3) apply(4'b0000, 1'b0);

      // Lone requester keeps the grant, then a newcomer preempts it.
      phase = "lone_then_preempt";
      apply(4'b0000, 1'b1);
      repeat (20) apply(4'b1000, 1'b0);
      repeat (6) apply(4'b1001, 1'b0);
      repeat (3) apply(4'b0000, 1'b0);

      // Owner drops on the very edge its quantum expires.
      phase = "drop_at_expiry";
      apply(4'b0000, 1'b1);
      repeat (8) apply(4'b0011, 1'b0);
      repeat (4) apply(4'b0010, 1'b0);
      repeat (3) apply(4'b0000, 1'b0);

      // Reset while device 2 owns the grant, then restart from pointer 0.
      phase = "reset_mid_grant";
      apply(4'b0000, 1'b1);
      repeat (3) apply(4'b0100, 1'b0);
      apply(4'b0100, 1'b1);
      repeat (4) apply(4'b1100, 1'b0);

      // Randomised level requests with occasional reset.
      phase = "random";
      r = 4'b0000;
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
         apply(r, ($urandom_range(0, 299) == 0));
      end

      stim_done = 1;
      repeat (2) @(negedge clock);
      #1;
      check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
